// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Holds the requester count, select width, FSM encoding and default hold limit.
package rr_mux_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int HOLD_MAX_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Winner is the first set bit searching ptr+1, ptr+2, ptr+3, ptr.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [SEL_W-1:0] ptr
  );
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/fourto1mux.sv
// Team 4:1 single-bit mux with enable.
// Y is A[S] when E is set, otherwise 0; purely combinational.
module fourto1mux (
  input  logic [3:0] A,
  input  logic [1:0] S,
  input  logic       E,
  output logic       Y
);

  assign Y = E & A[S];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux; registered gnt/S/E.
// Define RR_MUX_TIMEOUT_EN to cap grant hold at HOLD_MAX cycles under contention.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] A,
  output logic [3:0] gnt,
  output logic [1:0] S,
  output logic       E,
  output logic       Y
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX out of range 2..255");
  end

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] s_q, s_d;
  logic       e_q, e_d;
  logic [1:0] ptr_q, ptr_d;

  logic [1:0] pick;
  logic       own_req;
  logic       others;
  logic       hold_exp;

  assign pick    = rr_pick(req, ptr_q);
  assign own_req = req[s_q];
  assign others  = |(req & ~(4'b0001 << s_q));

`ifdef RR_MUX_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_q, cnt_d;

  assign hold_exp = (cnt_q == HOLD_LIM);
`else
  assign hold_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    e_d     = e_q;
    ptr_d   = ptr_q;
`ifdef RR_MUX_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick;
          s_d     = pick;
          e_d     = 1'b1;
          ptr_d   = pick;
`ifdef RR_MUX_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (!own_req && !others) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          e_d     = 1'b0;
`ifdef RR_MUX_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else if (!own_req || (hold_exp && others)) begin
          // ptr equals the owner here, so the owner is searched last
          gnt_d   = 4'b0001 << pick;
          s_d     = pick;
          ptr_d   = pick;
`ifdef RR_MUX_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
`ifdef RR_MUX_TIMEOUT_EN
          cnt_d   = hold_exp ? 8'd0 : cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        e_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      s_q     <= 2'b00;
      e_q     <= 1'b0;
      ptr_q   <= 2'b11;
`ifdef RR_MUX_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      e_q     <= e_d;
      ptr_q   <= ptr_d;
`ifdef RR_MUX_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt = gnt_q;
  assign S   = s_q;
  assign E   = e_q;

  fourto1mux u_mux (
    .A (A),
    .S (s_q),
    .E (e_q),
    .Y (Y)
  );

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum grant-hold cycles, used only when RR_MUX_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  4  request vector; req[i] is requester i asking for the shared 4:1 mux output.
REQ-005 A  input  4  data vector; A[i] is requester i's data bit into the mux.
REQ-006 gnt  output  4  registered one-hot grant, or all-zero when idle.
REQ-007 S  output  2  registered mux select; equals the index of the asserted gnt bit.
REQ-008 E  output  1  registered mux enable; 1 exactly when gnt is non-zero.
REQ-009 Y  output  1  mux output: A[S] when E=1, else 0; combinational from A, S and E.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no owner) and GRANT (one owner, index held in S).
REQ-011 Round-robin pointer ptr[1:0] SHALL hold the last granted index; search order is ptr+1, ptr+2, ptr+3, ptr (mod 4); first requester found in that order wins.
REQ-012 IDLE, req != 0 at an edge: that edge SHALL load the winner into gnt/S, set E=1 and ptr=winner, and enter GRANT; latency from req to gnt is one cycle.
REQ-013 IDLE, req == 0: SHALL remain IDLE with gnt=0, E=0, and S holding its last value.
REQ-014 GRANT, req[S]=1: SHALL hold gnt, S and E unchanged, apart from REQ-022.
REQ-015 GRANT, req[S]=0 with other requests pending: SHALL move to the next winner at the same edge (back-to-back, no idle cycle), with the departing owner searched last.
REQ-016 GRANT, req[S]=0 and req==0: SHALL return to IDLE at that edge; gnt=0, E=0.
REQ-017 At most one gnt bit SHALL be set in any cycle; gnt SHALL never assert for a requester whose req was 0 at the granting edge.
REQ-018 Changes to A SHALL reach Y in the same cycle, with no register on the data path.

Reset
REQ-019 rst=1 at an edge SHALL force: state=IDLE, gnt=4'b0000, S=2'b00, E=0, ptr=2'b11 (requester 0 has first priority), hold counter=0; Y reads 0.
REQ-020 Reset asserted mid-GRANT SHALL drop the grant on that edge, regardless of req; rst overrides all other transitions.

Configuration
REQ-021 Macro RR_MUX_TIMEOUT_EN SHALL gate a grant-hold timeout.
REQ-022 With RR_MUX_TIMEOUT_EN defined: an 8-bit hold counter clears on every new grant and increments each GRANT cycle. When it reaches HOLD_MAX-1 while req[S]=1 and another req bit is set, the next edge SHALL re-arbitrate per REQ-015 as if req[S] had dropped. If the owner is the only requester, the grant is kept and the counter clears.
REQ-023 Without RR_MUX_TIMEOUT_EN: no counter is present, and an owner holds the grant for as long as req[S]=1.

Structure
REQ-024 Shared package rr_mux_pkg SHALL hold: N_REQ=4, SEL_W=2, the state encoding (IDLE=1'b0, GRANT=1'b1) and the default HOLD_MAX.
REQ-025 The data path SHALL be one instance of the team's existing fourto1mux sub-module, with S and E driven from this block's registers; the arbiter holds no data-path logic of its own.

Verification
REQ-026 After reset, req=4'b1111 -> next cycle gnt=0001, S=00, E=1; owner drops req[0] -> gnt=0010 at the next edge, then 0100, then 1000, each with no idle gap.
REQ-027 req=4'b0100 held, A=4'b0100 -> gnt=0100, S=10, Y=1; toggle A[2]=0 -> Y=0 in the same cycle.
REQ-028 Single requester req=0010 pulsed for 3 cycles then 0 -> gnt=0010 for 3 cycles, then IDLE with E=0 and Y=0.
REQ-029 With RR_MUX_TIMEOUT_EN and HOLD_MAX=4: req=0011 held continuously -> grant alternates 0001 and 0010 every 4 cycles. With only req=0001 held -> grant stays 0001 indefinitely.
REQ-030 rst asserted for 1 cycle while gnt=1000 with req=1111 -> gnt=0000 after the rst edge, then gnt=0001 on the following edge (ptr restarted at 11).
REQ-031 Random req/A stimulus over 10k cycles -> checker confirms gnt is one-hot or zero, S matches gnt, E=|gnt, Y=E&A[S], and no requester waits more than 3 grants while continuously requesting (timeout build).
